// File: rtl/md5_msg_padder.sv
// ----------------------------------------------------------------------------
// md5_msg_padder
//
// Byte-stream front end for an MD5 compression core. Packs message bytes into
// 32-bit little-endian words M[0..15] and appends MD5 padding: a 0x80 byte,
// zero bytes, then the 64-bit message bit length in little-endian order. The
// downstream core only ever sees complete 512-bit blocks.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid      in_data / in_last valid
//   in_ready      padder accepts a byte this cycle
//   in_data       message byte
//   in_last       final byte of the message (qualified by in_valid)
//   out_valid     out_word valid
//   out_ready     consumer accepts the word
//   out_word      message word, first byte of the word in bits [7:0]
//   out_idx       word index within the block (0..15)
//   out_blk_last  out_idx == 15
//   out_msg_last  length-high word of the final block
// ----------------------------------------------------------------------------
module md5_msg_padder #(
  parameter int CNT_W = 61
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_idx,
  output logic        out_blk_last,
  output logic        out_msg_last
);

  typedef enum logic [1:0] {
    DATA,    // packing message bytes
    ZERO,    // zero padding (optionally the 0x80 word first)
    LEN_LO,  // bit length [31:0] at word 14
    LEN_HI   // bit length [63:32] at word 15
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   byte_cnt, cnt_n;
  logic [1:0]         lane, lane_n;
  logic [3:0]         widx, widx_n;
  logic [31:0]        wbuf, wbuf_n;
  // Set when the message ended exactly on a word boundary, so the 0x80 byte
  // still has to go out as the first padding word.
  logic               pad80, pad80_n;

  logic               slot_free;
  logic               load;
  logic [31:0]        ld_word;
  logic               ld_msg_last;
  logic [31:0]        merged;
  logic [63:0]        bitlen;

  assign slot_free = !out_valid || out_ready;
  assign bitlen    = 64'({byte_cnt, 3'b000});

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_n     = state;
    cnt_n       = byte_cnt;
    lane_n      = lane;
    widx_n      = widx;
    wbuf_n      = wbuf;
    pad80_n     = pad80;
    load        = 1'b0;
    ld_word     = '0;
    ld_msg_last = 1'b0;
    merged      = wbuf;
    in_ready    = 1'b0;

    unique case (state)
      DATA: begin
        in_ready = !rst && slot_free;
        if (in_valid && in_ready) begin
          merged[int'(lane)*8 +: 8] = in_data;
          cnt_n = byte_cnt + 1'b1;
          if (in_last) begin
            // Short final word: 0x80 goes straight into the next lane; the
            // higher lanes are already zero because wbuf is cleared per word.
            if (lane != 2'd3) merged[(int'(lane) + 1)*8 +: 8] = 8'h80;
            load    = 1'b1;
            ld_word = merged;
            widx_n  = widx + 4'd1;
            lane_n  = 2'd0;
            wbuf_n  = '0;
            pad80_n = (lane == 2'd3);
            // If the last data word (already carrying 0x80) sits at word 13,
            // the length words follow immediately with no zero fill.
            if (lane != 2'd3 && widx == 4'd13) state_n = LEN_LO;
            else                                state_n = ZERO;
          end else if (lane == 2'd3) begin
            load    = 1'b1;
            ld_word = merged;
            widx_n  = widx + 4'd1;
            lane_n  = 2'd0;
            wbuf_n  = '0;
          end else begin
            wbuf_n = merged;
            lane_n = lane + 2'd1;
          end
        end
      end

      ZERO: begin
        // Zero-fills up to word 13 of the current block; when widx wraps past
        // 15 this naturally spills into a fresh block.
        if (slot_free) begin
          load    = 1'b1;
          ld_word = pad80 ? 32'h0000_0080 : 32'h0;
          pad80_n = 1'b0;
          widx_n  = widx + 4'd1;
          if (widx == 4'd13) state_n = LEN_LO;
        end
      end

      LEN_LO: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_word = bitlen[31:0];
          widx_n  = widx + 4'd1;
          state_n = LEN_HI;
        end
      end

      LEN_HI: begin
        // Once the final word is committed to the output register the message
        // is complete; counters clear so the next message can start at once.
        if (slot_free) begin
          load        = 1'b1;
          ld_word     = bitlen[63:32];
          ld_msg_last = 1'b1;
          cnt_n       = '0;
          lane_n      = 2'd0;
          widx_n      = 4'd0;
          state_n     = DATA;
        end
      end

      default: state_n = DATA;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= DATA;
      byte_cnt     <= '0;
      lane         <= 2'd0;
      widx         <= 4'd0;
      wbuf         <= '0;
      pad80        <= 1'b0;
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_idx      <= 4'd0;
      out_blk_last <= 1'b0;
      out_msg_last <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= cnt_n;
      lane     <= lane_n;
      widx     <= widx_n;
      wbuf     <= wbuf_n;
      pad80    <= pad80_n;
      if (load) begin
        // load only happens with a free slot, so this never overwrites a
        // word the consumer has not taken.
        out_valid    <= 1'b1;
        out_word     <= ld_word;
        out_idx      <= widx;
        out_blk_last <= (widx == 4'd15);
        out_msg_last <= ld_msg_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/md5_msg_padder.md
Name: md5_msg_padder

Overview:
- Front-end feeder for the MD5 compression datapath, upstream of the round engine that evaluates the per-round F/G/H/I functions.
- Accepts a message as a byte stream with a valid/ready handshake.
- Emits 32-bit little-endian message words M[0..15], one 512-bit block at a time.
- Inserts MD5 padding: a 0x80 byte, then zero bytes, then the 64-bit message bit length in little-endian order, so the core sees only complete, correctly formatted blocks.

Parameters:
- CNT_W, 61, width of the message byte counter. Bit length = {byte_cnt, 3'b000}, zero-extended to 64 bits.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  padder accepts byte this cycle
- in_data  input  8  message byte
- in_last  input  1  final byte of message (qualified by in_valid)
- out_valid  output  1  out_word valid
- out_ready  input  1  consumer accepts word
- out_word  output  32  message word, first byte of word in bits [7:0]
- out_idx  output  4  word index within block (0..15)
- out_blk_last  output  1  out_idx==15
- out_msg_last  output  1  final word (length-high word) of final block

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_word=0, out_idx=0, out_blk_last=0, out_msg_last=0, in_ready=0.
  - Internal: state=DATA, byte_cnt=0, lane=0, widx=0, word buffer=0.
  - in_ready may rise the cycle after rst deasserts.
- Output register: a single stage. Contents hold stable while out_valid && !out_ready. A transfer occurs when out_valid && out_ready.
- Output slot free: an output slot is free when !out_valid || out_ready.
- States: DATA, ZERO, LEN_LO, LEN_HI.
- DATA:
  - in_ready = slot free.
  - On an accepted byte: write it to the buffer lane, lane++, byte_cnt++.
  - If lane was 3 and !in_last: load the word into the output register next cycle (latency 1), widx++, lane=0.
  - If in_last and lane<3: write 0x80 to lane+1 and zeros to the higher lanes, then emit the word. Next state: ZERO.
  - If in_last and lane==3: emit the full data word. The 0x80 byte goes in byte 0 of the next word (PAD80 handled as the first ZERO-state word = 0x00000080). Next state: ZERO.
- ZERO (in_ready=0):
  - Emit one padding word per free slot.
  - The length words must occupy widx 14/15 of a block.
  - If the last data word landed at widx 14 or 15: zero-fill to widx 15, then a fresh block with zeros through widx 13.
  - Otherwise zeros through widx 13.
- LEN_LO: emit bitlen[31:0] at widx 14.
- LEN_HI: emit bitlen[63:32] at widx 15 with out_msg_last=1. On its transfer, clear byte_cnt/lane/widx and return to DATA.
- widx wraps 15->0. out_idx/out_blk_last are registered with out_word.
- Throughput: one word per cycle when out_ready is held high; padding never stalls except on out_ready.
- Simultaneous out transfer and new word load in the same cycle is legal (slot free).
- Zero-length messages are unsupported; every message has at least 1 byte carrying in_last.
- byte_cnt wraps modulo 2^CNT_W. Bit length is therefore modulo 2^64, per MD5.
- rst mid-message discards all buffered state: out_valid drops the next cycle and no partial block completes.
- in_data/in_last are ignored when !in_ready.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), out_ready=1:
  - Required: word0=0x80636261, words1..13=0, word14=0x00000018, word15=0x00000000 with out_msg_last=1.
  - Exactly 16 words.
- "abcd", 4 bytes:
  - Required: word0=0x64636261, word1=0x00000080, words2..13=0, word14=0x00000020, word15=0.
- 55 bytes of 0x41:
  - Required: single block, word13=0x80414141, word14=0x000001B8.
- 56 bytes of 0x41:
  - Required: block 1 word14=0x00000080, word15=0, out_msg_last=0.
  - Required: block 2 words0..13=0, word14=0x000001C0, out_msg_last=1 on word15.
- 64 bytes, then a back-to-back second message "a" (0x61):
  - Required for the 64-byte message: block 2 word0=0x00000080, word14=0x00000200.
  - Required for "a": the next block starts with word0=0x00008061.
- Random out_ready stalls on "abc", plus assertion of rst at word 5 of a stream:
  - Required with stalls: out_word/out_idx stable while stalled, and an identical word sequence.
  - Required after rst: out_valid=0 the next cycle, and a fresh "abc" yields the exact block above.
